// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite data-memory slave: response codes, read FSM
// states and the address window test used by both the read and write paths.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    // Widened to 34 bits so BASE + span cannot wrap at the top of the map.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [33:0] span
    );
        logic [33:0] off;
        off = {2'b00, addr} - {2'b00, base};
        return (addr >= base) && (off < span);
    endfunction

    function automatic logic [31:0] addr_offset(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return addr - base;
    endfunction

endpackage

// File: rtl/datmem_array.sv
// DEPTH x 32 word storage with per-byte write enables and a registered read
// port. Contents are deliberately not reset.
module datmem_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // A same-edge read of the word being written returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_lite_datmem_slave.sv
// AXI4-Lite slave exposing a DEPTH-word data memory at BASE_ADDR, with
// independent AW/W holding registers and a read FSM with RD_WAIT extra cycles.
module axi_lite_datmem_slave
    import axi_lite_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RD_WAIT   = 0
) (
    input  logic        ACLK,
    input  logic        ARSTN,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W     = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
    localparam logic [33:0] SPAN      = 34'(DEPTH) * 34'd4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_WAIT);

    // ---------------- write path ----------------
    logic        aw_held;
    logic        w_held;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        commit;
    logic        wr_ok;
    logic [31:0] wr_off;

    assign AWREADY = ~aw_held & ~BVALID;
    assign WREADY  = ~w_held & ~BVALID;
    assign commit  = aw_held & w_held;
    assign wr_ok   = addr_in_range(awaddr_q, BASE_ADDR, SPAN);
    assign wr_off  = addr_offset(awaddr_q, BASE_ADDR);

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= wr_ok ? OKAY : SLVERR;
        end else begin
            if (AWVALID && AWREADY) aw_held <= 1'b1;
            if (WVALID && WREADY)   w_held  <= 1'b1;
            if (BVALID && BREADY)   BVALID  <= 1'b0;
        end
    end

    // ---------------- read path ----------------
    rd_state_t        state;
    rd_state_t        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [31:0]      araddr_q;
    logic [31:0]      rd_addr;
    logic [31:0]      rd_off;
    logic             rd_ok;
    logic             capture;
    logic [31:0]      arr_rdata;

    assign ARREADY = (state == R_IDLE);
    assign RVALID  = (state == R_RESP);
    assign rd_ok   = addr_in_range(rd_addr, BASE_ADDR, SPAN);
    assign rd_off  = addr_offset(rd_addr, BASE_ADDR);

    // With no wait cycles the array is addressed straight from ARADDR so the
    // data lands on the handshake edge itself.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        rd_addr = araddr_q;
        unique case (state)
            R_IDLE: begin
                if (ARVALID && ARREADY) begin
                    if (RD_WAIT == 0) begin
                        state_n = R_RESP;
                        capture = 1'b1;
                        rd_addr = ARADDR;
                    end else begin
                        state_n = R_WAIT;
                        cnt_n   = WAIT_LOAD;
                    end
                end
            end
            R_WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt_n == '0) begin
                    state_n = R_RESP;
                    capture = 1'b1;
                end
            end
            R_RESP: begin
                if (RREADY) state_n = R_IDLE;
            end
            default: state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            state <= R_IDLE;
            cnt   <= '0;
            RRESP <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture) RRESP <= rd_ok ? OKAY : SLVERR;
        end
    end

    always_ff @(posedge ACLK) begin
        if (AWVALID && AWREADY) awaddr_q <= AWADDR;
        if (WVALID && WREADY) begin
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
        end
        if (ARVALID && ARREADY) araddr_q <= ARADDR;
    end

    // Array read register has no reset; RDATA is masked to zero outside a
    // valid in-range response, which also covers reset and SLVERR reads.
    assign RDATA = (RVALID && (RRESP == OKAY)) ? arr_rdata : '0;

    datmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (ACLK),
        .we    (commit & wr_ok),
        .be    (wstrb_q),
        .waddr (wr_off[IDX_W+1:2]),
        .wdata (wdata_q),
        .re    (capture),
        .raddr (rd_off[IDX_W+1:2]),
        .rdata (arr_rdata)
    );

    logic unused_bits;
    assign unused_bits = ^{wr_off[1:0], wr_off[31:IDX_W+2], rd_off[1:0], rd_off[31:IDX_W+2]};

endmodule

// File: tb/tb_axi_lite_datmem_slave.sv
// Bench for axi_lite_datmem_slave: dut0 (RD_WAIT=0, base 0, 1024 words) and
// dut1 (RD_WAIT=3, base 0x1000, 16 words), table vectors plus corner sequences.
module tb_axi_lite_datmem_slave;

    localparam logic [31:0] BASE1 = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arstn   [2];
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];

    axi_lite_datmem_slave #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .RD_WAIT(0)) dut0 (
        .ACLK(clk), .ARSTN(arstn[0]),
        .AWADDR(awaddr[0]), .AWVALID(awvalid[0]), .AWREADY(awready[0]),
        .WDATA(wdata[0]), .WSTRB(wstrb[0]), .WVALID(wvalid[0]), .WREADY(wready[0]),
        .BRESP(bresp[0]), .BVALID(bvalid[0]), .BREADY(bready[0]),
        .ARADDR(araddr[0]), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
        .RDATA(rdata[0]), .RRESP(rresp[0]), .RVALID(rvalid[0]), .RREADY(rready[0])
    );

    axi_lite_datmem_slave #(.DEPTH(16), .BASE_ADDR(BASE1), .RD_WAIT(3)) dut1 (
        .ACLK(clk), .ARSTN(arstn[1]),
        .AWADDR(awaddr[1]), .AWVALID(awvalid[1]), .AWREADY(awready[1]),
        .WDATA(wdata[1]), .WSTRB(wstrb[1]), .WVALID(wvalid[1]), .WREADY(wready[1]),
        .BRESP(bresp[1]), .BVALID(bvalid[1]), .BREADY(bready[1]),
        .ARADDR(araddr[1]), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
        .RDATA(rdata[1]), .RRESP(rresp[1]), .RVALID(rvalid[1]), .RREADY(rready[1])
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    rexp_t      rq[$];
    logic [1:0] bq[$];
    vec_t       vt[10];
    int         passed = 0;
    int         total  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h want %08h", name, act, exp);
    endtask

    task automatic collect_b(input int d);
        int n = 0;
        logic [1:0] e;
        while (!bvalid[d] && n < 20) begin tick(); n++; end
        if (!bvalid[d]) begin
            check("b_timeout", 32'd0, 32'd1);
            return;
        end
        e = bq.pop_front();
        check("bresp", {30'd0, bresp[d]}, {30'd0, e});
        bready[d] = 1'b1;
        tick();
        bready[d] = 1'b0;
        check("bvalid_clear", {31'd0, bvalid[d]}, 32'd0);
    endtask

    task automatic collect_r(input int d);
        rexp_t e;
        if (!rvalid[d]) begin
            check("r_timeout", 32'd0, 32'd1);
            return;
        end
        e = rq.pop_front();
        check("rdata", rdata[d], e.data);
        check("rresp", {30'd0, rresp[d]}, {30'd0, e.resp});
        rready[d] = 1'b1;
        tick();
        rready[d] = 1'b0;
        check("rvalid_clear", {31'd0, rvalid[d]}, 32'd0);
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input logic [1:0] exp_resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw, hs_w;
        int n = 0;
        while (!(aw_done && w_done) && n < 40) begin
            if (!aw_done && n >= aw_dly) begin awvalid[d] = 1'b1; awaddr[d] = addr; end
            if (!w_done && n >= w_dly) begin wvalid[d] = 1'b1; wdata[d] = data; wstrb[d] = strb; end
            hs_aw = awvalid[d] && awready[d];
            hs_w  = wvalid[d] && wready[d];
            tick();
            n++;
            if (hs_aw) begin aw_done = 1; awvalid[d] = 1'b0; end
            if (hs_w)  begin w_done  = 1; wvalid[d]  = 1'b0; end
        end
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 32'd0, 32'd1);
            awvalid[d] = 1'b0;
            wvalid[d]  = 1'b0;
            return;
        end
        check("bvalid_not_early", {31'd0, bvalid[d]}, 32'd0);
        bq.push_back(exp_resp);
        tick();
        check("bvalid_1cyc", {31'd0, bvalid[d]}, 32'd1);
        check("awready_wready_low_bvalid", {30'd0, awready[d], wready[d]}, 32'd0);
        collect_b(d);
    endtask

    task automatic do_read(input int d, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        int n = 0;
        int lat;
        rexp_t e;
        arvalid[d] = 1'b1;
        araddr[d]  = addr;
        while (!arready[d] && n < 20) begin tick(); n++; end
        if (!arready[d]) begin
            check("ar_timeout", 32'd0, 32'd1);
            arvalid[d] = 1'b0;
            return;
        end
        tick();
        arvalid[d] = 1'b0;
        e.data = exp_data;
        e.resp = exp_resp;
        rq.push_back(e);
        lat = 1;
        while (!rvalid[d] && lat < 20) begin tick(); lat++; end
        check("rd_latency", lat, (d == 0) ? 32'd1 : 32'd4);
        collect_r(d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1);
    end

    initial begin
        vt[0] = '{32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 32'hDEADBEEF, 2'b00};
        vt[1] = '{32'h0000_0020, 32'hAAAAAAAA, 4'hF, 0, 0, 2'b00, 32'hAAAAAAAA, 2'b00};
        vt[2] = '{32'h0000_0020, 32'h11223344, 4'h5, 3, 0, 2'b00, 32'hAA22AA44, 2'b00};
        vt[3] = '{32'h0000_0020, 32'h55555555, 4'h0, 0, 0, 2'b00, 32'hAA22AA44, 2'b00};
        vt[4] = '{32'h0000_0000, 32'h00000000, 4'hF, 2, 0, 2'b00, 32'h00000000, 2'b00};
        vt[5] = '{32'h0000_0003, 32'hA1B2C3D4, 4'h8, 0, 0, 2'b00, 32'hA1000000, 2'b00};
        vt[6] = '{32'h0000_0FFC, 32'hCAFEF00D, 4'hF, 0, 2, 2'b00, 32'hCAFEF00D, 2'b00};
        vt[7] = '{32'h0000_1000, 32'h12345678, 4'hF, 0, 0, 2'b10, 32'h00000000, 2'b10};
        vt[8] = '{32'hFFFF_FFFC, 32'h0BADF00D, 4'hF, 1, 0, 2'b10, 32'h00000000, 2'b10};
        vt[9] = '{32'h0000_0024, 32'h0F0F0F0F, 4'hF, 1, 1, 2'b00, 32'h0F0F0F0F, 2'b00};

        for (int d = 0; d < 2; d++) begin
            arstn[d] = 1'b0;
            awaddr[d] = '0; awvalid[d] = 1'b0;
            wdata[d] = '0; wstrb[d] = '0; wvalid[d] = 1'b0;
            bready[d] = 1'b0;
            araddr[d] = '0; arvalid[d] = 1'b0;
            rready[d] = 1'b0;
        end

        // Reset state
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_bvalid", {31'd0, bvalid[d]}, 32'd0);
            check("rst_rvalid", {31'd0, rvalid[d]}, 32'd0);
            check("rst_resps", {28'd0, bresp[d], rresp[d]}, 32'd0);
            check("rst_rdata", rdata[d], 32'd0);
        end
        #3;
        arstn[0] = 1'b1;
        arstn[1] = 1'b1;
        tick();
        for (int d = 0; d < 2; d++)
            check("rst_readies", {29'd0, awready[d], wready[d], arready[d]}, 32'd7);

        // Table vectors on dut0
        for (int i = 0; i < 10; i++) begin
            do_write(0, vt[i].addr, vt[i].data, vt[i].strb, vt[i].aw_dly, vt[i].w_dly, vt[i].bresp);
            do_read(0, vt[i].addr, vt[i].rdata, vt[i].rresp);
        end
        // Out-of-range writes above must not have aliased onto words 0 / 1023
        do_read(0, 32'h0000_0000, 32'hA1000000, 2'b00);
        do_read(0, 32'h0000_0FFC, 32'hCAFEF00D, 2'b00);

        // Same-edge commit and read capture on word 0x10 returns the old data
        awvalid[0] = 1'b1; awaddr[0] = 32'h10;
        wvalid[0] = 1'b1; wdata[0] = 32'h01010101; wstrb[0] = 4'hF;
        tick();
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        arvalid[0] = 1'b1; araddr[0] = 32'h10;
        tick();
        arvalid[0] = 1'b0;
        check("same_edge_rvalid", {31'd0, rvalid[0]}, 32'd1);
        check("same_edge_old_data", rdata[0], 32'hDEADBEEF);
        check("same_edge_bvalid", {31'd0, bvalid[0]}, 32'd1);
        bready[0] = 1'b1; rready[0] = 1'b1;
        tick();
        bready[0] = 1'b0; rready[0] = 1'b0;
        do_read(0, 32'h10, 32'h01010101, 2'b00);

        // dut1: RD_WAIT=3 with BREADY/RREADY held low
        awvalid[1] = 1'b1; awaddr[1] = BASE1 + 32'h8;
        wvalid[1] = 1'b1; wdata[1] = 32'h13572468; wstrb[1] = 4'hF;
        tick();
        awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        tick();
        check("stall_bvalid_rise", {31'd0, bvalid[1]}, 32'd1);
        arvalid[1] = 1'b1; araddr[1] = BASE1 + 32'h8;
        tick();
        arvalid[1] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check("stall_bvalid_hold", {31'd0, bvalid[1]}, 32'd1);
            check("stall_bresp", {30'd0, bresp[1]}, 32'd0);
            check("stall_aw_w_ready_low", {30'd0, awready[1], wready[1]}, 32'd0);
            check("stall_rvalid", {31'd0, rvalid[1]}, (i >= 4) ? 32'd1 : 32'd0);
            if (i >= 4) begin
                check("stall_rdata", rdata[1], 32'h13572468);
                check("stall_rresp", {30'd0, rresp[1]}, 32'd0);
            end
            if (i < 8) tick();
        end
        bready[1] = 1'b1; rready[1] = 1'b1;
        tick();
        bready[1] = 1'b0; rready[1] = 1'b0;
        check("stall_release_valids", {30'd0, bvalid[1], rvalid[1]}, 32'd0);
        check("stall_release_readies", {29'd0, awready[1], wready[1], arready[1]}, 32'd7);

        // dut1: window edges and aliasing of out-of-range addresses
        do_write(1, BASE1,          32'h11110000, 4'hF, 0, 0, 2'b00);
        do_write(1, BASE1 + 32'h3C, 32'h76543210, 4'hF, 0, 0, 2'b00);
        do_write(1, BASE1 - 32'h4,  32'hEEEEEEEE, 4'hF, 0, 1, 2'b10);
        do_write(1, BASE1 + 32'h40, 32'hDDDDDDDD, 4'hF, 1, 0, 2'b10);
        do_read(1, BASE1,          32'h11110000, 2'b00);
        do_read(1, BASE1 + 32'h3C, 32'h76543210, 2'b00);
        do_read(1, BASE1 + 32'h40, 32'h00000000, 2'b10);
        do_read(1, BASE1 - 32'h4,  32'h00000000, 2'b10);

        // dut1: async reset with AW held and read in R_WAIT
        awvalid[1] = 1'b1; awaddr[1] = BASE1 + 32'h4;
        tick();
        awvalid[1] = 1'b0;
        check("aw_held_awready", {31'd0, awready[1]}, 32'd0);
        arvalid[1] = 1'b1; araddr[1] = BASE1 + 32'h4;
        tick();
        arvalid[1] = 1'b0;
        check("r_wait_arready", {31'd0, arready[1]}, 32'd0);
        #3;
        arstn[1] = 1'b0;
        #1;
        check("async_rst_valids", {30'd0, bvalid[1], rvalid[1]}, 32'd0);
        check("async_rst_readies", {29'd0, awready[1], wready[1], arready[1]}, 32'd7);
        tick();
        tick();
        #3;
        arstn[1] = 1'b1;
        tick();
        check("post_rst_readies", {29'd0, awready[1], wready[1], arready[1]}, 32'd7);
        check("post_rst_no_rvalid", {31'd0, rvalid[1]}, 32'd0);
        wvalid[1] = 1'b1; wdata[1] = 32'hFFFFFFFF; wstrb[1] = 4'hF;
        tick();
        wvalid[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("dropped_aw_no_bvalid", {31'd0, bvalid[1]}, 32'd0);
            tick();
        end
        awvalid[1] = 1'b1; awaddr[1] = BASE1 + 32'h4;
        tick();
        awvalid[1] = 1'b0;
        bq.push_back(2'b00);
        tick();
        check("late_aw_bvalid", {31'd0, bvalid[1]}, 32'd1);
        collect_b(1);
        do_read(1, BASE1 + 32'h4, 32'hFFFFFFFF, 2'b00);

        // dut0: async reset with B and R responses both pending
        awvalid[0] = 1'b1; awaddr[0] = 32'h30;
        wvalid[0] = 1'b1; wdata[0] = 32'h5A5A5A5A; wstrb[0] = 4'hF;
        arvalid[0] = 1'b1; araddr[0] = 32'h20;
        tick();
        awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
        tick();
        check("pre_rst_valids", {30'd0, bvalid[0], rvalid[0]}, 32'd3);
        check("pre_rst_rdata", rdata[0], 32'hAA22AA44);
        #3;
        arstn[0] = 1'b0;
        #1;
        check("rst_drop_valids", {30'd0, bvalid[0], rvalid[0]}, 32'd0);
        check("rst_drop_rdata", rdata[0], 32'd0);
        check("rst_drop_resps", {28'd0, bresp[0], rresp[0]}, 32'd0);
        tick();
        #3;
        arstn[0] = 1'b1;
        tick();
        check("rst0_release_readies", {29'd0, awready[0], wready[0], arready[0]}, 32'd7);
        do_read(0, 32'h20, 32'hAA22AA44, 2'b00);
        do_read(0, 32'h30, 32'h5A5A5A5A, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
